// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states and the minimum bit divisor.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for the serial line.
// Both flops reset to 1 so an idle-high line never looks like a start edge.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 by default, one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err output.
module uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [15:0]           baud_div,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  busy
);

  import uart_pkg::*;

  if (CLK_FREQ <= 0 || DATA_WIDTH < 1 || DATA_WIDTH > 8) begin : g_bad_cfg
    $error("uart_rx: unsupported CLK_FREQ or DATA_WIDTH");
  end

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  state_t                state, state_d;
  logic                  rx_s, rx_prev;
  logic                  fall, tick, half_tick, par_ok;
  logic [15:0]           div, cnt;
  logic [2:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign fall      = rx_prev & ~rx_s;
  assign tick      = cnt == div - 16'd1;
  assign half_tick = cnt == (div >> 1) - 16'd1;
  assign busy      = state != IDLE;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ~(^shreg ^ par_bit);
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (fall) state_d = START;
      START: if (half_tick) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (tick && bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_prev    <= 1'b1;
      div        <= MIN_DIV;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      rx_prev    <= rx_s;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // restart the bit timer on every state change and every data bit
      if (state_d != state || (state == DATA && tick))
        cnt <= '0;
      else if (state != IDLE)
        cnt <= cnt + 16'd1;

      if (state == IDLE && fall) begin
        div     <= (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
        bit_cnt <= '0;
      end

      if (state == DATA && tick) begin
        shreg   <= DATA_WIDTH'({rx_s, shreg} >> 1);
        bit_cnt <= bit_cnt + 3'd1;
      end

`ifdef UART_RX_PARITY_EN
      if (state == PARITY && tick)
        par_bit <= rx_s;
`endif

      if (state == STOP && tick) begin
        if (rx_s && par_ok) begin
          data_out   <= shreg;
          data_valid <= 1'b1;
        end
        frame_err  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err <= ~par_ok;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with a FIFO write model.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] baud_div = 16'd16;
  logic [7:0]  data_out;
  logic        data_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
  logic        bad_par = 1'b0;
  int          pecnt = 0;
`endif

  int tests = 0, fails = 0, bit_len = 16;
  int cyc = 0, vcnt = 0, fecnt = 0, v_cyc = 0, consec = 0;
  logic prev_v = 1'b0;
  logic [7:0] fifo_q[$];

  uart_rx #(
    .CLK_FREQ   (50000000),
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud_div   (baud_div),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // FIFO write side: every valid strobe pushes data_out, no full check
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    prev_v <= data_valid;
    if (data_valid) begin
      vcnt  <= vcnt + 1;
      v_cyc <= cyc;
      fifo_q.push_back(data_out);
      if (prev_v) consec <= consec + 1;
    end
    if (frame_err) fecnt <= fecnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pecnt <= pecnt + 1;
`endif
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    tick_n(bit_len);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b ^ bad_par);
`endif
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick_n(3);
    tests++;
    if (data_out !== 8'h00) begin
      fails++; $display("FAIL reset_data_out: got %0h want 0", data_out);
    end
    tests++;
    if (data_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", data_valid);
    end
    tests++;
    if (frame_err !== 1'b0) begin
      fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b want 0", busy);
    end
`ifdef UART_RX_PARITY_EN
    tests++;
    if (parity_err !== 1'b0) begin
      fails++; $display("FAIL reset_parity_err: got %b want 0", parity_err);
    end
`endif
    rst = 1'b0;
    tick_n(4);
  endtask

  task automatic test_basic;
    int t0, v0, f0, lat;
    baud_div = 16'd16;
    bit_len  = 16;
    v0 = vcnt; f0 = fecnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    tick_n(4);
    lat = v_cyc - t0;
    tests++;
    if (vcnt - v0 != 1) begin
      fails++; $display("FAIL basic_pulses: got %0d want 1", vcnt - v0);
    end
    tests++;
    if (data_out !== 8'hA5) begin
      fails++; $display("FAIL basic_data: got %0h want a5", data_out);
    end
    tests++;
    if (lat < 150 || lat > 160) begin
      fails++; $display("FAIL basic_latency: got %0d want 150..160", lat);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL basic_busy: got %b want 0", busy);
    end
    tests++;
    if (fecnt != f0) begin
      fails++; $display("FAIL basic_frame_err: got %0d want 0", fecnt - f0);
    end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = vcnt; f0 = fecnt;
    rx = 1'b0;
    tick_n(5);
    rx = 1'b1;
    tick_n(1);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL glitch_busy_start: got %b want 1", busy);
    end
    tick_n(6);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL glitch_idle_by_12: got %b want 0", busy);
    end
    tick_n(30);
    tests++;
    if (vcnt != v0 || fecnt != f0) begin
      fails++;
      $display("FAIL glitch_strobes: got valid %0d err %0d want 0 0",
               vcnt - v0, fecnt - f0);
    end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = vcnt; f0 = fecnt;
    send_frame(8'h3C, 1'b0);
    tick_n(20);
    tests++;
    if (fecnt - f0 != 1) begin
      fails++; $display("FAIL ferr_pulse: got %0d want 1", fecnt - f0);
    end
    tests++;
    if (vcnt != v0) begin
      fails++; $display("FAIL ferr_valid: got %0d want 0", vcnt - v0);
    end
    tests++;
    if (data_out !== 8'hA5) begin
      fails++; $display("FAIL ferr_data_kept: got %0h want a5", data_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [3];
    int v0, c0;
    exp = '{8'h01, 8'hFF, 8'h80};
    fifo_q.delete();
    v0 = vcnt; c0 = consec;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    tick_n(4);
    tests++;
    if (vcnt - v0 != 3 || fifo_q.size() != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d pulses %0d entries want 3",
               vcnt - v0, fifo_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= fifo_q.size()) begin
        fails++; $display("FAIL b2b_read%0d: got empty want %0h", i, exp[i]);
      end else if (fifo_q[i] !== exp[i]) begin
        fails++;
        $display("FAIL b2b_read%0d: got %0h want %0h", i, fifo_q[i], exp[i]);
      end
    end
    tests++;
    if (consec != c0) begin
      fails++; $display("FAIL b2b_distinct: got %0d adjacent want 0", consec - c0);
    end
  endtask

  task automatic test_baud_latch;
    logic [7:0] b;
    int v0;
    b = 8'h69;
    v0 = vcnt;
    baud_div = 16'd16;
    bit_len  = 16;
    rx = 1'b0;
    tick_n(6);
    baud_div = 16'd7;
    tick_n(10);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(1'b1);
    tick_n(4);
    baud_div = 16'd16;
    tests++;
    if (vcnt - v0 != 1 || data_out !== 8'h69) begin
      fails++;
      $display("FAIL baud_latch: got %0d pulses data %0h want 1 69",
               vcnt - v0, data_out);
    end
  endtask

  task automatic test_min_div;
    int v0;
    v0 = vcnt;
    baud_div = 16'd2;
    bit_len  = 4;
    send_frame(8'hC6, 1'b1);
    tick_n(8);
    tests++;
    if (vcnt - v0 != 1 || data_out !== 8'hC6) begin
      fails++;
      $display("FAIL min_div: got %0d pulses data %0h want 1 c6",
               vcnt - v0, data_out);
    end
    baud_div = 16'd16;
    bit_len  = 16;
    tick_n(4);
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    int v0, f0;
    b = 8'h96;
    v0 = vcnt; f0 = fecnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    tick_n(8);
    rst = 1'b1;
    tick_n(1);
    tests++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 ||
        frame_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_outputs: got %0h %b %b %b want 0 0 0 0",
               data_out, data_valid, frame_err, busy);
    end
    rst = 1'b0;
    rx  = 1'b1;
    tick_n(40);
    tests++;
    if (vcnt != v0 || fecnt != f0) begin
      fails++;
      $display("FAIL midrst_no_strobe: got valid %0d err %0d want 0 0",
               vcnt - v0, fecnt - f0);
    end
    send_frame(8'h5A, 1'b1);
    tick_n(4);
    tests++;
    if (vcnt - v0 != 1 || data_out !== 8'h5A) begin
      fails++;
      $display("FAIL midrst_resume: got %0d pulses data %0h want 1 5a",
               vcnt - v0, data_out);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = vcnt; p0 = pecnt;
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1);
    tick_n(4);
    tests++;
    if (pecnt - p0 != 1 || vcnt != v0) begin
      fails++;
      $display("FAIL parity_bad: got perr %0d valid %0d want 1 0",
               pecnt - p0, vcnt - v0);
    end
    bad_par = 1'b0;
    v0 = vcnt; p0 = pecnt;
    send_frame(8'h07, 1'b1);
    tick_n(4);
    tests++;
    if (pecnt != p0 || vcnt - v0 != 1 || data_out !== 8'h07) begin
      fails++;
      $display("FAIL parity_good: got perr %0d valid %0d data %0h want 0 1 07",
               pecnt - p0, vcnt - v0, data_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_baud_latch();
    test_min_div();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock in Hz (documentation and bench use only).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, number of payload bits per frame.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port baud_div  input  16  clock cycles per bit.
REQ-007 SHALL have port data_out  output  DATA_WIDTH  last received byte, drives the downstream FIFO din.
REQ-008 SHALL have port data_valid  output  1  one-cycle strobe, drives the downstream FIFO wr_en.
REQ-009 SHALL have port frame_err  output  1  one-cycle strobe, stop bit sampled low.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer before any use; the synchronized line is referred to here as rx_s.
REQ-012 SHALL implement the FSM states IDLE, START, DATA, STOP, plus PARITY when it is compiled in.
REQ-013 SHALL leave IDLE for START on an rx_s 1->0 transition, and latch baud_div at that moment; baud_div changes during a frame SHALL be ignored.
REQ-014 SHALL treat latched baud_div values below 4 as 4.
REQ-015 SHALL re-sample rx_s in START after baud_div/2 cycles (integer division): low goes to DATA, high returns to IDLE silently (glitch reject, no strobe).
REQ-016 SHALL sample rx_s in DATA every baud_div cycles, DATA_WIDTH times, LSB first, into a shift register; a 3-bit bit counter SHALL wrap to STOP after the last bit.
REQ-017 SHALL sample the stop bit in STOP after baud_div cycles: high loads data_out and pulses data_valid for exactly 1 cycle; low pulses frame_err for 1 cycle and leaves data_out unchanged.
REQ-018 SHALL assert the strobe in the cycle after the stop sample and return to IDLE in the same cycle.
REQ-019 SHALL make data_out and data_valid go high together; data_out SHALL hold its value until the next good frame.
REQ-020 SHALL allow back-to-back frames: a falling edge in the cycle following the return to IDLE SHALL be accepted.
REQ-021 SHALL NOT assert data_valid on two consecutive cycles, so that every strobe forms a distinct rising edge for the downstream FIFO.
REQ-022 SHALL NOT monitor downstream FIFO full status; a byte written into a full FIFO is dropped there.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set the FSM to IDLE, clear all counters and the shift register, set data_out=0, data_valid=0, frame_err=0, busy=0, and set both synchronizer flops to 1.
REQ-024 SHALL abort any frame in progress on reset without any strobe; after release, reception SHALL resume at the next falling edge.

Configuration
REQ-025 SHALL, when macro UART_RX_PARITY_EN is defined, add the PARITY state between DATA and STOP, sampling one even-parity bit after baud_div cycles.
REQ-026 SHALL, with UART_RX_PARITY_EN defined, add output parity_err (1 bit, reset 0): on mismatch, pulse parity_err 1 cycle alongside the stop-bit outcome and suppress data_valid.
REQ-027 SHALL, without UART_RX_PARITY_EN defined, omit both the PARITY state and the parity_err port; the frame is 8N1.

Structure
REQ-028 SHALL place the FSM state encodings and the minimum-divisor constant (4) in shared package uart_pkg, for reuse by the planned uart_tx.
REQ-029 SHALL implement the synchronizer as sub-module uart_sync2 (clk, rst, d, q; reset value 1); the remainder SHALL be a single module.

Verification
REQ-030 SHALL cover: baud_div=16, send 0xA5 8N1 -> data_out=0xA5, a single data_valid pulse 150-160 cycles after the falling edge, busy low afterwards.
REQ-031 SHALL cover: rx low for 5 cycles, then high, baud_div=16 -> no data_valid, no frame_err, FSM back in IDLE by cycle 12.
REQ-032 SHALL cover: 0x3C sent with stop bit forced low -> frame_err single pulse, data_valid stays 0, data_out keeps its previous value.
REQ-033 SHALL cover: 0x01, 0xFF, 0x80 sent back-to-back with no idle gap into the fifo model -> three distinct data_valid pulses, and the FIFO reads back 0x01, 0xFF, 0x80.
REQ-034 SHALL cover: rst=1 during bit 4 of a frame -> no strobe, all outputs 0 the next cycle, then the following frame 0x5A is received correctly.
REQ-035 SHALL cover: with UART_RX_PARITY_EN defined, 0x07 sent with parity bit 0 -> parity_err pulse and no data_valid; sent with parity bit 1 -> data_valid and data_out=0x07.
